// File: rtl/imm_gen_queue.sv
// rtl/imm_gen_queue.sv - RISC-V immediate generator feeding a DEPTH-entry tag/immediate FIFO
// Optional feature macro: IMM_GEN_ZIMM_EN (sel 110 yields the zero-extended CSR zimm).
module imm_gen_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [2:0]               in_imm_sel,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      imm32;
  logic             sel_illegal;
  logic [XLEN-1:0]  imm_ext;

  // Every format keeps instr[31] as bit 31 of imm32 (zimm leaves it 0), so one
  // signed widening covers the XLEN=64 extension for all formats.
  always_comb begin
    imm32       = '0;
    sel_illegal = 1'b0;
    case (in_imm_sel)
      3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b011: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      3'b100: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      3'b101: imm32 = {in_instr[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
      3'b110: imm32 = {27'b0, in_instr[19:15]};
`endif
      default: sel_illegal = 1'b1;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic             ill_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the outputs below are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      imm_mem_q[wr_ptr_q] <= sel_illegal ? '0 : imm_ext;
      tag_mem_q[wr_ptr_q] <= in_tag;
      ill_mem_q[wr_ptr_q] <= sel_illegal;
    end
  end

  assign out_imm     = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_tag     = out_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign out_illegal = out_valid ? ill_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imm_gen_queue.sv
// tb/tb_imm_gen_queue.sv - directed plus random check of imm_gen_queue against a queue model
module tb_imm_gen_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_sel;
  logic [4:0]  in_tag;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a;
  logic [4:0]  out_tag_a;
  logic [1:0]  occ_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [4:0]  out_tag_b;
  logic [2:0]  occ_b;

  imm_gen_queue #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_tag(out_tag_a), .out_illegal(out_illegal_a), .occupancy(occ_a)
  );

  imm_gen_queue #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_tag(out_tag_b), .out_illegal(out_illegal_b), .occupancy(occ_b)
  );

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic longint sx(input longint raw, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (raw >= half) ? raw - (half * 2) : raw;
  endfunction

  function automatic ent_t ref_entry(input logic [31:0] ins, input logic [2:0] sel,
                                     input logic [4:0] tag);
    ent_t   e;
    longint v;
    v     = 0;
    e.ill = 1'b0;
    case (sel)
      3'd0: v = sx(longint'(ins[31:20]), 12);
      3'd1: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
      3'd3: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                   + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd4: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                   + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd5: v = sx(longint'(ins[31:12]) * 4096, 32);
`ifdef IMM_GEN_ZIMM_EN
      3'd6: v = longint'(ins[19:15]);
`endif
      default: e.ill = 1'b1;
    endcase
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  task automatic check_model();
    chk("a_valid", out_valid_a, qa.size() != 0);
    chk("a_ready", in_ready_a, qa.size() < 2);
    chk("a_occ", occ_a, qa.size());
    chk("a_imm", out_imm_a, qa.size() ? {32'b0, qa[0].imm[31:0]} : 64'b0);
    chk("a_tag", out_tag_a, qa.size() ? qa[0].tag : 5'b0);
    chk("a_ill", out_illegal_a, qa.size() ? qa[0].ill : 1'b0);
    chk("b_valid", out_valid_b, qb.size() != 0);
    chk("b_ready", in_ready_b, qb.size() < 4);
    chk("b_occ", occ_b, qb.size());
    chk("b_imm", out_imm_b, qb.size() ? qb[0].imm : 64'b0);
    chk("b_tag", out_tag_b, qb.size() ? qb[0].tag : 5'b0);
    chk("b_ill", out_illegal_b, qb.size() ? qb[0].ill : 1'b0);
  endtask

  task automatic tick();
    ent_t e;
    bit   pa, pb, oa, ob;
    if (chk_en) check_model();
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      e  = ref_entry(in_instr, in_imm_sel, in_tag);
      pa = in_valid && (qa.size() < 2);
      pb = in_valid && (qb.size() < 4);
      oa = out_ready && (qa.size() > 0);
      ob = out_ready && (qb.size() > 0);
      if (oa) void'(qa.pop_front());
      if (ob) void'(qb.pop_front());
      if (pa) qa.push_back(e);
      if (pb) qb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] s,
                       input logic [4:0] t, input bit ordy);
    in_valid   = v;
    in_instr   = ins;
    in_imm_sel = s;
    in_tag     = t;
    out_ready  = ordy;
  endtask

  logic [31:0] ti [4] = '{32'hFE112E23, 32'h00000463, 32'hFFDFF06F, 32'h123450B7};
  logic [2:0]  ts [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
  logic [31:0] te [4] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h12345000};

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    @(negedge clk);
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_occ", occ_a, 0);
    chk("rst_imm", out_imm_a, 0);

    drive(1, 32'hFFF00093, 3'b000, 5'd1, 1);
    tick();
    drive(0, 32'h0, 3'b000, 5'd0, 1);
    chk("i_valid", out_valid_a, 1);
    chk("i_imm32", out_imm_a, 32'hFFFFFFFF);
    chk("i_imm64", out_imm_b, 64'hFFFFFFFFFFFFFFFF);
    chk("i_tag", out_tag_a, 1);
    chk("i_ill", out_illegal_a, 0);
    tick();

    for (int k = 0; k < 4; k++) begin
      drive(1, ti[k], ts[k], 5'(k + 2), 1);
      tick();
      chk("seq_imm", out_imm_a, te[k]);
      chk("seq_tag", out_tag_a, k + 2);
    end
    drive(0, 32'h0, 3'b000, 5'd0, 1);
    tick();
    chk("seq_empty", out_valid_a, 0);

    drive(1, ti[0], ts[0], 5'd10, 0); tick();
    drive(1, ti[1], ts[1], 5'd11, 0); tick();
    drive(1, ti[2], ts[2], 5'd12, 0); tick();
    chk("bp_full_occ", occ_a, 2);
    chk("bp_full_rdy", in_ready_a, 0);
    chk("bp_head", out_tag_a, 10);
    drive(1, ti[2], ts[2], 5'd12, 1); tick();
    chk("bp_pop_occ", occ_a, 1);
    chk("bp_pop_rdy", in_ready_a, 1);
    chk("bp_pop_head", out_tag_a, 11);
    drive(1, ti[2], ts[2], 5'd12, 0); tick();
    chk("bp_refill_occ", occ_a, 2);
    drive(0, 32'h0, 3'b000, 5'd0, 1); tick();
    chk("bp_order", out_tag_a, 12);
    repeat (4) tick();

    drive(1, 32'hDEADBEEF, 3'b010, 5'd7, 1); tick();
    drive(0, 32'h0, 3'b000, 5'd0, 1);
    chk("ill_flag", out_illegal_a, 1);
    chk("ill_imm", out_imm_a, 0);
    chk("ill_tag", out_tag_a, 7);
    chk("ill_imm64", out_imm_b, 0);
    tick();
    drive(1, 32'h000F5073, 3'b110, 5'd8, 1); tick();
    drive(0, 32'h0, 3'b000, 5'd0, 1);
`ifdef IMM_GEN_ZIMM_EN
    chk("zimm_imm", out_imm_a, 32'h1E);
    chk("zimm_ill", out_illegal_a, 0);
`else
    chk("zimm_imm", out_imm_a, 0);
    chk("zimm_ill", out_illegal_a, 1);
`endif
    tick();

    drive(1, 32'h800000B7, 3'b101, 5'd9, 1); tick();
    drive(0, 32'h0, 3'b000, 5'd0, 1);
    chk("u64_imm", out_imm_b, 64'hFFFFFFFF80000000);
    chk("u32_imm", out_imm_a, 32'h80000000);
    tick();

    drive(1, ti[0], ts[0], 5'd3, 0); tick(); tick();
    chk("mid_fill", occ_a, 2);
    rst = 1'b1;
    drive(1, ti[1], ts[1], 5'd4, 0); tick();
    rst = 1'b0;
    drive(0, 32'h0, 3'b000, 5'd0, 0);
    chk("mid_occ", occ_a, 0);
    chk("mid_valid", out_valid_a, 0);
    chk("mid_imm", out_imm_a, 0);
    chk("mid_tag", out_tag_a, 0);
    chk("mid_ill", out_illegal_a, 0);
    chk("mid_ready", in_ready_a, 1);
    chk("mid_occ64", occ_b, 0);
    tick();

    repeat (500) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(bit'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
            5'($urandom), bit'($urandom_range(0, 2) != 0));
      tick();
    end
    rst = 1'b0;
    drive(0, 32'h0, 3'b000, 5'd0, 1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
